// File: rtl/timer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared state encoding, BCD limits and time-value type for the
//            microwave keypad time-entry stage.
// Revision : 1.0 - initial release
// ============================================================================
package timer_pkg;

  // Controller states, 3-bit encoding
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_RUN    = 3'd2;
  localparam logic [2:0] ST_PAUSED = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  // BCD digit limits
  localparam logic [3:0] DIG_MAX  = 4'd9;
  localparam logic [3:0] TENS_MAX = 4'd5;

  // Three-digit time value M:ST:SU
  typedef struct packed {
    logic [3:0] min;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_time_t;

  // Fold an out-of-range tens-of-seconds digit into the minutes digit.
  // 60..99 seconds worth of tens become one more minute; at 9 minutes
  // there is nowhere to carry, so the value saturates at 9:5x.
  function automatic bcd_time_t normalise(input bcd_time_t t);
    bcd_time_t r;
    r = t;
    if (t.tens > TENS_MAX) begin
      if (t.min < DIG_MAX) begin
        r.min  = t.min + 4'd1;
        r.tens = t.tens - 4'd6;
      end else begin
        r.min  = DIG_MAX;
        r.tens = TENS_MAX;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_entry_shreg.sv
`default_nettype none
// ============================================================================
// Module   : bcd_entry_shreg
// Brief    : Three-digit BCD entry register. Shifts keypad digits in from
//            the units end, clears, and can overwrite itself with its own
//            normalised value.
// Revision : 1.0 - initial release
// ============================================================================
module bcd_entry_shreg
  import timer_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic       clear,
  input  logic       shift,
  input  logic [3:0] digit,
  input  logic       norm_load,
  output bcd_time_t  value
);

  bcd_time_t value_q;
  bcd_time_t value_d;
  bcd_time_t w_norm;
  bcd_time_t w_base;

  // Normaliser is purely combinational on the held value
  assign w_norm = normalise(value_q);

  // Next value: a shift combined with a clear lands the digit in a zeroed register
  always_comb begin
    value_d = value_q;
    w_base  = clear ? '0 : value_q;
    if (norm_load) begin
      value_d = w_norm;
    end else if (shift) begin
      value_d = '{min: w_base.tens, tens: w_base.units, units: digit};
    end else if (clear) begin
      value_d = '0;
    end
  end

  // Digit storage
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule
`default_nettype wire

// File: rtl/keypad_time_entry.sv
`default_nettype none
// ============================================================================
// Module   : keypad_time_entry
// Brief    : Keypad time entry and run control for the microwave timer
//            chain: collects M:ST:SU, loads the down-counters, gates the
//            1 Hz enable and sequences start / pause / stop / done.
// Revision : 1.0 - initial release
// ============================================================================
module keypad_time_entry
  import timer_pkg::*;
#(
  parameter int BEEP_TICKS = 3,
  parameter int BEEP_W     = 2
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       key_valid,
  input  logic [3:0] key_digit,
  input  logic       start,
  input  logic       stop,
  input  logic       door_open,
  input  logic       tick,
  input  logic       timer_zero,
  output logic [3:0] data_min,
  output logic [3:0] data_tens,
  output logic [3:0] data_units,
  output logic       loadn,
  output logic       en,
  output logic       running,
  output logic       done
);

  localparam logic [BEEP_W-1:0] C_BEEP_LAST = BEEP_W'(BEEP_TICKS - 1);
  localparam logic [BEEP_W-1:0] C_BEEP_ONE  = BEEP_W'(1);

  logic [2:0]        state_q, state_d;
  logic [BEEP_W-1:0] beep_q, beep_d;
  logic              loadn_q, loadn_d;
  logic              running_q, running_d;
  logic              done_q, done_d;

  logic              w_clear, w_shift, w_norm;
  logic              w_key_ok, w_nonzero;
  bcd_time_t         w_value;

  assign w_key_ok  = key_valid && (key_digit <= DIG_MAX);
  assign w_nonzero = |w_value;

  bcd_entry_shreg u_entry (
    .clk       (clk),
    .clrn      (clrn),
    .clear     (w_clear),
    .shift     (w_shift),
    .digit     (key_digit),
    .norm_load (w_norm),
    .value     (w_value)
  );

  // State, beep counter and registered outputs
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= ST_IDLE;
      beep_q    <= '0;
      loadn_q   <= 1'b1;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beep_q    <= beep_d;
      loadn_q   <= loadn_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  // Next state and digit-register control; door_open outranks stop, start, keys
  always_comb begin
    state_d = state_q;
    beep_d  = beep_q;
    w_clear = 1'b0;
    w_shift = 1'b0;
    w_norm  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (door_open) begin
          // open door freezes entry entirely
        end else if (stop) begin
          w_clear = 1'b1;
        end else if (start) begin
          // start consumes the cycle even when ignored for an empty time
          if (w_nonzero) begin
            w_norm  = 1'b1;
            state_d = ST_LOAD;
          end
        end else if (w_key_ok) begin
          w_shift = 1'b1;
        end
      end
      ST_LOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        // the chain's zero flag is already valid on the first RUN cycle
        if (timer_zero) begin
          state_d = ST_DONE;
          beep_d  = '0;
        end else if (door_open || stop) begin
          state_d = ST_PAUSED;
        end
      end
      ST_PAUSED: begin
        if (door_open) begin
          // stay paused until the door is shut
        end else if (stop) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (door_open || stop) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
          beep_d  = '0;
        end else if (w_key_ok) begin
          state_d = ST_IDLE;
          w_clear = 1'b1;
          w_shift = 1'b1;
          beep_d  = '0;
        end else if (tick) begin
          if (beep_q == C_BEEP_LAST) begin
            state_d = ST_IDLE;
            w_clear = 1'b1;
            beep_d  = '0;
          end else begin
            beep_d = beep_q + C_BEEP_ONE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beep_d  = '0;
      end
    endcase
  end

  // Registered outputs follow the state being entered
  always_comb begin
    loadn_d   = (state_d != ST_LOAD);
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
  end

  // Count enable is combinational so it tracks tick and the door in the same cycle
  assign en = (state_q == ST_RUN) && tick && !door_open;

  assign data_min   = w_value.min;
  assign data_tens  = w_value.tens;
  assign data_units = w_value.units;
  assign loadn      = loadn_q;
  assign running    = running_q;
  assign done       = done_q;

endmodule
`default_nettype wire
